// File: rtl/peripheral_gcd.sv
// Chip-select bus peripheral that computes the GCD of two unsigned operands
// with the binary (Stein) algorithm, one step per clock.
module peripheral_gcd #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  input  logic             cs,
  input  logic [4:0]       addr,
  input  logic             rd,
  input  logic             wr,
  output logic [31:0]      d_out
);

  localparam int KW = $clog2(WIDTH) + 1;

  localparam logic [4:0] ADDR_A      = 5'h04;
  localparam logic [4:0] ADDR_B      = 5'h08;
  localparam logic [4:0] ADDR_INIT   = 5'h0C;
  localparam logic [4:0] ADDR_RESULT = 5'h10;
  localparam logic [4:0] ADDR_STATUS = 5'h14;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SHIFT,
    S_LOOP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [KW-1:0]    k_q, k_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic        wr_en;
  logic        init_start;
  logic [31:0] rd_data;

  assign wr_en      = cs & wr;
  assign init_start = wr_en && (addr == ADDR_INIT) && d_in[0];

  // NOTE: every variable assigned in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    rd_data = '0;
    unique case (addr)
      ADDR_A:      rd_data = 32'(a_q);
      ADDR_B:      rd_data = 32'(b_q);
      ADDR_RESULT: rd_data = 32'(result_q);
      ADDR_STATUS: rd_data = {30'b0, busy_q, done_q};
      default:     rd_data = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    k_d      = k_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = done_q;

    unique case (state_q)
      S_CHECK: begin
        if (x_q == '0 || y_q == '0) begin
          result_d = x_q | y_q;
          state_d  = S_DONE;
        end else if (x_q[0] | y_q[0]) begin
          state_d = S_LOOP;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        x_d = x_q >> 1;
        y_d = y_q >> 1;
        k_d = k_q + KW'(1);
        // Bit 1 becomes the new LSB: leave once either shifted value is odd.
        if (x_q[1] | y_q[1]) state_d = S_LOOP;
      end
      S_LOOP: begin
        if (x_q == '0) begin
          result_d = y_q << k_q;
          state_d  = S_DONE;
        end else if (!x_q[0]) begin
          x_d = x_q >> 1;
        end else if (!y_q[0]) begin
          y_d = y_q >> 1;
        end else if (x_q >= y_q) begin
          x_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    // A start request wins over whatever step was in flight.
    if (init_start) begin
      x_d     = a_q;
      y_d     = b_q;
      k_d     = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      state_d = S_CHECK;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      x_q      <= '0;
      y_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      d_out    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      k_q      <= k_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      if (wr_en && addr == ADDR_A) a_q <= d_in;
      if (wr_en && addr == ADDR_B) b_q <= d_in;
      if (cs && rd) d_out <= rd_data;
    end
  end

endmodule

// File: tb/tb_peripheral_gcd.sv
// Self-checking bench for peripheral_gcd: directed register-map scenarios plus
// random operands checked against a Euclid-based GCD model.
module tb_peripheral_gcd;

  localparam int W         = 16;
  localparam int MAX_POLLS = 4 * W + 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  d_in;
  logic          cs, rd, wr;
  logic [4:0]    addr;
  logic [31:0]   d_out;

  int n_checks = 0;
  int n_fail   = 0;

  peripheral_gcd #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .d_in  (d_in),
    .cs    (cs),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .d_out (d_out)
  );

  always #5 clk = ~clk;

  function automatic int gcd_ref(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic bus_write(input logic [4:0] a, input logic [W-1:0] d);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = d;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] q);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    @(posedge clk); #1;
    q = d_out;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_read(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] q;
    bus_read(a, q);
    n_checks++;
    if (q !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, q, exp);
    end
  endtask

  // Polls STATUS until done; a poll count beyond the latency bound is a failure.
  task automatic wait_done(input string name);
    logic [31:0] q;
    int polls = 0;
    bit ok = 1'b0;
    while (polls < MAX_POLLS && !ok) begin
      bus_read(5'h14, q);
      polls++;
      n_checks++;
      if (q[1:0] === 2'b11) begin
        n_fail++;
        $display("FAIL %s busy_and_done: status 0x%0h", name, q);
      end
      if (q[0] === 1'b1) ok = 1'b1;
    end
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s timeout: done not seen after %0d polls, expected within %0d", name, polls, MAX_POLLS);
    end
  endtask

  task automatic run_gcd(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
    bus_write(5'h04, a);
    bus_write(5'h08, b);
    bus_write(5'h0C, 16'h0001);
    wait_done(name);
    expect_read({name, " result"}, 5'h10, 32'(gcd_ref(int'(a), int'(b))));
    expect_read({name, " status"}, 5'h14, 32'h1);
  endtask

  task automatic test_reset();
    n_checks++;
    if (d_out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset d_out: got 0x%0h, expected 0x0", d_out);
    end
    expect_read("reset A", 5'h04, 32'h0);
    expect_read("reset B", 5'h08, 32'h0);
    expect_read("reset RESULT", 5'h10, 32'h0);
    expect_read("reset STATUS", 5'h14, 32'h0);
  endtask

  task automatic test_basic();
    run_gcd("gcd_48_18", 16'd48, 16'd18);
    expect_read("gcd_48_18 value", 5'h10, 32'd6);
    run_gcd("gcd_1024_96", 16'd1024, 16'd96);
    expect_read("gcd_1024_96 value", 5'h10, 32'd32);
    run_gcd("gcd_ffff", 16'hFFFF, 16'hFFFF);
    expect_read("gcd_ffff value", 5'h10, 32'd65535);
  endtask

  task automatic test_zero_operand();
    bus_write(5'h04, 16'd0);
    bus_write(5'h08, 16'd7);
    bus_write(5'h0C, 16'h0001);
    expect_read("zero status edge1", 5'h14, 32'h2);
    expect_read("zero status edge2 pre-edge", 5'h14, 32'h2);
    expect_read("zero status edge3", 5'h14, 32'h1);
    expect_read("zero result", 5'h10, 32'd7);
    run_gcd("gcd_0_0", 16'd0, 16'd0);
  endtask

  task automatic test_restart();
    bus_write(5'h04, 16'd48);
    bus_write(5'h08, 16'd18);
    bus_write(5'h0C, 16'h0001);
    idle(3);
    bus_write(5'h04, 16'd21);
    bus_write(5'h08, 16'd14);
    bus_write(5'h0C, 16'h0001);
    wait_done("restart");
    expect_read("restart result", 5'h10, 32'd7);
    expect_read("restart A", 5'h04, 32'd21);
    expect_read("restart B", 5'h08, 32'd14);
  endtask

  task automatic test_mid_reset();
    bus_write(5'h04, 16'd1024);
    bus_write(5'h08, 16'd96);
    bus_write(5'h0C, 16'h0001);
    idle(3);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    n_checks++;
    if (d_out !== 32'h0) begin
      n_fail++;
      $display("FAIL midreset d_out: got 0x%0h, expected 0x0", d_out);
    end
    expect_read("midreset STATUS", 5'h14, 32'h0);
    idle(6);
    expect_read("midreset STATUS later", 5'h14, 32'h0);
    expect_read("midreset RESULT", 5'h10, 32'h0);
    expect_read("midreset A", 5'h04, 32'h0);
    run_gcd("after_reset", 16'd1024, 16'd96);
  endtask

  task automatic test_bus_corners();
    bus_write(5'h04, 16'h1234);
    // Read and write in the same cycle: data returned is the old value.
    cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = 5'h04; d_in = 16'h5678;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0; wr = 1'b0;
    n_checks++;
    if (d_out !== 32'h1234) begin
      n_fail++;
      $display("FAIL rdwr_collision: got 0x%0h, expected 0x1234", d_out);
    end
    expect_read("rdwr new A", 5'h04, 32'h5678);
    expect_read("unmapped 0x1C", 5'h1C, 32'h0);
    expect_read("status before init0", 5'h14, 32'h1);
    bus_write(5'h0C, 16'hFFFE);
    idle(2);
    expect_read("init0 no start", 5'h14, 32'h1);
    cs = 1'b0; wr = 1'b1; addr = 5'h04; d_in = 16'hBEEF;
    @(posedge clk); #1;
    wr = 1'b0;
    expect_read("cs0 write ignored", 5'h04, 32'h5678);
    cs = 1'b0; rd = 1'b1; addr = 5'h10;
    @(posedge clk); #1;
    rd = 1'b0;
    n_checks++;
    if (d_out !== 32'h5678) begin
      n_fail++;
      $display("FAIL d_out hold without cs: got 0x%0h, expected 0x5678", d_out);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    int sh;
    for (int i = 0; i < 24; i++) begin
      sh = int'($urandom_range(0, 5));
      a  = W'($urandom_range(0, 2047) << sh);
      b  = W'($urandom_range(1, 2047) << sh);
      if (i % 8 == 7) a = W'($urandom);
      run_gcd($sformatf("rand%0d_%0d_%0d", i, a, b), a, b);
    end
  endtask

  initial begin
    reset = 1'b1;
    cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; d_in = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    test_reset();
    test_basic();
    test_zero_operand();
    test_restart();
    test_mid_reset();
    test_bus_corners();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
